hdlc_bitstuff_tx: RTL and testbench
===================================

HDLC_BITSTUFF_TX -- requirements
Module: hdlc_bitstuff_tx

Interface
REQ-001 The block SHALL have parameter IDLE_FLAGS, default 0: 0 = idle line sends continuous 1s, 1 = idle line sends back-to-back flags.
REQ-002 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-003 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-004 in_data  input  8  payload byte, sent LSB first.
REQ-005 in_valid  input  1  in_data/in_last valid.
REQ-006 in_last  input  1  byte is the final byte of the frame.
REQ-007 in_ready  output  1  byte is taken at the edge where in_valid && in_ready.
REQ-008 abort  input  1  single-cycle request to abort the current frame.
REQ-009 out  output  1  registered serial line bit, one bit per clk.
REQ-010 busy  output  1  high from the first opening-flag bit to the last closing-flag or abort bit.
REQ-011 underrun  output  1  one-cycle pulse when a byte is needed mid-frame and in_valid is low.

Function
REQ-012 States SHALL be IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT; flag = 01111110 (0x7E; symmetric, so bit order is irrelevant).
REQ-013 In IDLE, out SHALL be 1 when IDLE_FLAGS=0, or repeated flag bits when IDLE_FLAGS=1.
REQ-014 In IDLE, in_ready SHALL be 1 when IDLE_FLAGS=0, and only during the last bit of an idle flag when IDLE_FLAGS=1.
REQ-015 When a first byte is accepted at edge N, out SHALL carry the 8 opening-flag bits in cycles N+1..N+8 and data bit0 at N+9.
REQ-016 The first byte SHALL be held internally during OPEN_FLAG; no in_ready is asserted during OPEN_FLAG.
REQ-017 In DATA, a ones counter SHALL count consecutive payload 1s across byte boundaries; after the fifth 1, the next out bit SHALL be an inserted 0 and the counter SHALL clear.
REQ-018 The ones counter SHALL clear on any payload 0 and on entry to DATA; flag and abort bits SHALL never be stuffed or counted.
REQ-019 in_ready SHALL be 1 in DATA during the cycle in which bit7 of the current byte is on out with no stuff bit due next, and the frame is not ending.
REQ-020 If a stuff bit is due after bit7, it SHALL be sent first and in_ready SHALL move to that stuff cycle.
REQ-021 If the current byte had in_last=1, after bit7 and any due stuff bit the block SHALL send CLOSE_FLAG (8 bits), then return to IDLE with in_ready per REQ-014.
REQ-022 The block SHALL NOT share the closing flag with the next opening flag; each frame gets its own opening flag.
REQ-023 If in_ready=1 in DATA and in_valid=0, the block SHALL pulse underrun and enter ABORT.
REQ-024 If abort=1 in OPEN_FLAG or DATA, the block SHALL discard the in-flight byte and enter ABORT at the next edge; abort in IDLE, CLOSE_FLAG or ABORT SHALL be ignored.
REQ-025 ABORT SHALL emit eight 1s, then enter IDLE.
REQ-026 During ABORT and CLOSE_FLAG, in_ready SHALL be 0.
REQ-027 The block SHALL accept back-to-back bytes with no idle bits between them when in_valid is held high.

Reset
REQ-028 On reset: state=IDLE, out=1, in_ready=0 for that cycle, busy=0, underrun=0, ones counter=0, bit index=0.
REQ-029 Reset asserted mid-frame SHALL truncate the frame without an abort sequence.
REQ-030 With IDLE_FLAGS=1, the idle-flag phase SHALL restart at flag bit0 on the cycle after reset.

Structure
REQ-031 A shared package hdlc_pkg SHALL hold the state enum, the FLAG=8'h7E constant, and STUFF_RUN=5, shared with the receive-side detector.
REQ-032 Stuffing logic SHALL sit in one sub-module, hdlc_zero_inserter: bit in, stuff request out, ones counter internal.
REQ-033 The framing FSM and byte shifter SHALL sit in hdlc_bitstuff_tx.

Verification
REQ-034 IDLE_FLAGS=0, one byte 0x00 with in_last -> out = 01111110, 00000000, 01111110, then 1s; busy high for 24 cycles.
REQ-035 One byte 0xFF with in_last -> 01111110, 111110111, 01111110; total frame length 25 bits.
REQ-036 Bytes 0xF0 then 0x0F(last) -> data bits 00001111 1 0 1110000 (stuff across the byte boundary); in_ready for byte 2 during the bit7 cycle of byte 1.
REQ-037 Byte 0x55 not last, then in_valid low -> underrun pulse in the bit7 cycle of 0x55, then eight 1s, then idle 1s.
REQ-038 abort in the third data cycle of 0xAA -> next eight bits all 1, busy falls after them, and no further 0xAA bits appear.
REQ-039 IDLE_FLAGS=1, in_valid raised in the third bit of an idle flag -> byte accepted at the last bit of that flag; next 8 bits are the opening flag; reset mid-DATA -> out=1 at the next cycle, then flags.

Source files
------------

// File: rtl/hdlc_pkg.sv
// hdlc_pkg: HDLC framing constants and transmit state encoding shared by tx and rx
package hdlc_pkg;
  typedef enum logic [2:0] {IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT} hdlc_state_t;
  localparam logic [7:0] FLAG = 8'h7E;
  localparam int STUFF_RUN = 5;
endpackage

// File: rtl/hdlc_bitstuff_tx_if.sv
// hdlc_bitstuff_tx_if: byte-stream handshake feeding the HDLC transmitter
interface hdlc_bitstuff_tx_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  modport master(output in_data, in_valid, in_last, input in_ready);
  modport slave(input in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/hdlc_zero_inserter.sv
// hdlc_zero_inserter: counts consecutive payload ones and requests a stuffed 0 after each run
module hdlc_zero_inserter
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift,
  input  logic din,
  input  logic ins,
  output logic stuff
);
  logic [2:0] ones;
  always_ff @(posedge clk)
    ones <= (reset || clr || ins) ? 3'd0 : shift ? (din ? ones + 3'd1 : 3'd0) : ones;
  assign stuff = ones == 3'(STUFF_RUN);
endmodule

// File: rtl/hdlc_bitstuff_tx.sv
// hdlc_bitstuff_tx: HDLC transmit framer with opening/closing flags, zero insertion and abort
module hdlc_bitstuff_tx
  import hdlc_pkg::*;
#(
  parameter int IDLE_FLAGS = 0
) (
  input  logic clk,
  input  logic reset,
  hdlc_bitstuff_tx_if.slave src,
  input  logic abort,
  output logic out,
  output logic busy,
  output logic underrun
);
  hdlc_state_t state, nstate;
  logic [2:0] idx, nidx;
  logic [7:0] sh, nsh;
  logic last_r, nlast, nout, fresh, rdy, take, byte_end, shift, din, ins, stuff, clr;
  // state/idx describe the bit currently on out; in DATA a stuff bit keeps idx of the bit before it
  assign byte_end = idx == 3'd7 && !stuff;
  assign rdy = !reset && !fresh && (state == IDLE ? (IDLE_FLAGS == 0 || idx == 3'd7)
                                                  : state == DATA && byte_end && !last_r && !abort);
  assign src.in_ready = rdy;
  assign take = rdy && src.in_valid;
  assign underrun = state == DATA && rdy && !src.in_valid;
  assign busy = state != IDLE;
  assign clr = nstate != DATA;
  hdlc_zero_inserter u_zi (
    .clk(clk), .reset(reset), .clr(clr), .shift(shift), .din(din), .ins(ins), .stuff(stuff)
  );
  always_comb begin
    nstate = state;
    nidx = idx + 3'd1;
    nout = out;
    nsh = sh;
    nlast = last_r;
    shift = 1'b0;
    din = sh[0];
    ins = 1'b0;
    unique case (state)
      IDLE:
        if (take) begin
          nstate = OPEN_FLAG;
          nidx = 3'd0;
          nout = FLAG[0];
          nsh = src.in_data;
          nlast = src.in_last;
        end else begin
          nidx = (fresh || IDLE_FLAGS == 0) ? 3'd0 : idx + 3'd1;
          nout = IDLE_FLAGS == 0 ? 1'b1 : FLAG[nidx];
        end
      OPEN_FLAG:
        if (abort) begin
          nstate = ABORT;
          nidx = 3'd0;
          nout = 1'b1;
        end else if (idx == 3'd7) begin
          nstate = DATA;
          nidx = 3'd0;
          nout = sh[0];
          nsh = sh >> 1;
          shift = 1'b1;
        end else
          nout = FLAG[nidx];
      DATA:
        if (abort) begin
          nstate = ABORT;
          nidx = 3'd0;
          nout = 1'b1;
        end else if (stuff) begin
          nidx = idx;
          nout = 1'b0;
          ins = 1'b1;
        end else if (idx != 3'd7) begin
          nout = sh[0];
          nsh = sh >> 1;
          shift = 1'b1;
        end else if (last_r) begin
          nstate = CLOSE_FLAG;
          nidx = 3'd0;
          nout = FLAG[0];
        end else if (src.in_valid) begin
          nidx = 3'd0;
          nout = src.in_data[0];
          nsh = {1'b0, src.in_data[7:1]};
          nlast = src.in_last;
          shift = 1'b1;
          din = src.in_data[0];
        end else begin
          nstate = ABORT;
          nidx = 3'd0;
          nout = 1'b1;
        end
      CLOSE_FLAG:
        if (idx == 3'd7) begin
          nstate = IDLE;
          nidx = 3'd0;
          nout = IDLE_FLAGS == 0 ? 1'b1 : FLAG[0];
        end else
          nout = FLAG[nidx];
      ABORT:
        if (idx == 3'd7) begin
          nstate = IDLE;
          nidx = 3'd0;
          nout = IDLE_FLAGS == 0 ? 1'b1 : FLAG[0];
        end else
          nout = 1'b1;
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= 3'd0;
      out <= 1'b1;
      sh <= 8'd0;
      last_r <= 1'b0;
      fresh <= 1'b1;
    end else begin
      state <= nstate;
      idx <= nidx;
      out <= nout;
      sh <= nsh;
      last_r <= nlast;
      fresh <= 1'b0;
    end
endmodule

// File: tb/tb_hdlc_bitstuff_tx.sv
// tb_hdlc_bitstuff_tx: vector table, directed corner cases and random frames against a stream model
module tb_hdlc_bitstuff_tx;
  logic clk = 1'b0, reset = 1'b1, abort = 1'b0, abort1 = 1'b0;
  logic out0, busy0, underrun0, out1, busy1, underrun1;
  int tests = 0, fails = 0;
  hdlc_bitstuff_tx_if if0();
  hdlc_bitstuff_tx_if if1();
  hdlc_bitstuff_tx #(.IDLE_FLAGS(0)) u0 (
    .clk(clk), .reset(reset), .src(if0), .abort(abort), .out(out0), .busy(busy0), .underrun(underrun0)
  );
  hdlc_bitstuff_tx #(.IDLE_FLAGS(1)) u1 (
    .clk(clk), .reset(reset), .src(if1), .abort(abort1), .out(out1), .busy(busy1), .underrun(underrun1)
  );
  always #5 clk = ~clk;
  typedef struct {
    int n;
    logic [31:0] by;
    string data;
  } vec_t;
  vec_t tv[6];
  task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic logic [127:0] s2v(input string s, input logic pad);
    logic [127:0] v;
    int j;
    v = {128{pad}};
    j = 0;
    for (int i = 0; i < s.len(); i++)
      if (s[i] == "0" || s[i] == "1") begin
        v[j] = s[i] == "1";
        j++;
      end
    return v;
  endfunction
  // Line image of a frame: flag, payload LSB first with a 0 after every five 1s, flag
  task automatic model(input logic [31:0] by, input int n, output int len, output logic [127:0] e);
    logic [7:0] fl;
    int ones;
    fl = 8'h7E;
    ones = 0;
    len = 0;
    e = '0;
    for (int i = 0; i < 8; i++) begin e[len] = fl[i]; len++; end
    for (int j = 0; j < n; j++)
      for (int i = 0; i < 8; i++) begin
        e[len] = by[8*j+i];
        len++;
        ones = by[8*j+i] ? ones + 1 : 0;
        if (ones == 5) begin e[len] = 1'b0; len++; ones = 0; end
      end
    for (int i = 0; i < 8; i++) begin e[len] = fl[i]; len++; end
  endtask
  task automatic run0(input logic [31:0] by, input int n, output int len, output logic [127:0] v);
    int k, cyc;
    logic started;
    k = 0; cyc = 0; started = 0; len = 0; v = '0;
    @(posedge clk); #1;
    if0.in_valid = 1; if0.in_data = by[7:0]; if0.in_last = n == 1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy0) begin v[len] = out0; len++; started = 1; end
      else if (started) break;
      if (if0.in_valid && if0.in_ready) begin
        @(posedge clk); #1;
        k++;
        if (k < n) begin if0.in_data = by[8*k +: 8]; if0.in_last = k == n - 1; end
        else if0.in_valid = 0;
      end
    end
    if0.in_valid = 0;
    check("frame_timeout", int'(cyc < 400), 1);
  endtask
  task automatic trace0(input logic [7:0] d, input logic lst, input int ab,
                        output logic [39:0] o, output logic [39:0] b, output logic [39:0] u);
    int w;
    w = 0;
    @(posedge clk); #1;
    if0.in_valid = 1; if0.in_data = d; if0.in_last = lst;
    @(negedge clk);
    while (!if0.in_ready && w < 50) begin @(negedge clk); w++; end
    check("trace_ready_wait", int'(w < 50), 1);
    @(posedge clk); #1;
    if0.in_valid = 0;
    for (int k = 0; k < 40; k++) begin
      abort = k == ab;
      @(negedge clk);
      o[k] = out0; b[k] = busy0; u[k] = underrun0;
      @(posedge clk); #1;
    end
    abort = 0;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [127:0] got, ev;
    logic [63:0] o1, b1, r1;
    logic [39:0] o, b, u;
    logic [31:0] by;
    logic seen_u1;
    int len, elen, acc, n;
    tv[0] = '{n: 1, by: 32'h00, data: "00000000"};
    tv[1] = '{n: 1, by: 32'hFF, data: "111110111"};
    tv[2] = '{n: 2, by: 32'h0FF0, data: "00001111101110000"};
    tv[3] = '{n: 1, by: 32'h7E, data: "011111010"};
    tv[4] = '{n: 2, by: 32'hFFFF, data: "1111101111101111101"};
    tv[5] = '{n: 3, by: 32'h80001F, data: "1111100000000000000000001"};
    if0.in_valid = 0; if0.in_data = 0; if0.in_last = 0;
    if1.in_valid = 0; if1.in_data = 0; if1.in_last = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    acc = -1; o1 = '0; b1 = '0; r1 = '0; seen_u1 = 0;
    for (int k = 0; k < 41; k++) begin
      if1.in_valid = k >= 3 && acc < 0; if1.in_data = 8'h3C; if1.in_last = 1;
      @(negedge clk);
      o1[k] = out1; b1[k] = busy1; r1[k] = if1.in_ready;
      seen_u1 = seen_u1 | underrun1;
      if (k == 0) begin
        check("rst_out", out0, 1);
        check("rst_busy", busy0, 0);
        check("rst_underrun", underrun0, 0);
        check("rst_ready", if0.in_ready, 0);
      end
      if (k == 1) check("idle_ready", if0.in_ready, 1);
      if (if1.in_valid && if1.in_ready) acc = k;
      @(posedge clk); #1;
    end
    if1.in_valid = 0;
    check("flag_accept_cycle", acc, 8);
    ev = s2v("1 01111110 01111110 00111100 01111110 01111110", 0);
    check("flag_frame_out", o1, ev[63:0]);
    check("flag_frame_busy", b1, 64'hFFFFFF << 9);
    check("flag_ready", r1, (64'd1 << 8) | (64'd1 << 40));
    check("flag_underrun", seen_u1, 0);
    if1.in_valid = 1; if1.in_data = 8'h00; if1.in_last = 0;
    n = 0;
    @(negedge clk);
    while (!if1.in_ready && n < 20) begin @(negedge clk); n++; end
    check("flag_ready_wait", int'(n < 20), 1);
    @(posedge clk); #1;
    o1 = '0; b1 = '0; r1 = '0;
    for (int k = 0; k < 20; k++) begin
      reset = k == 10;
      if (k == 11) if1.in_valid = 0;
      @(negedge clk);
      o1[k] = out1; b1[k] = busy1; r1[k] = if1.in_ready;
      @(posedge clk); #1;
    end
    reset = 0;
    ev = s2v("01111110 000 1 01111110", 0);
    check("midreset_out", o1, ev[63:0]);
    check("midreset_busy", b1, 64'h7FF);
    check("midreset_ready", r1, 64'd1 << 19);
    for (int i = 0; i < 6; i++) begin
      run0(tv[i].by, tv[i].n, len, got);
      ev = s2v({"01111110", tv[i].data, "01111110"}, 0);
      check($sformatf("vec%0d_len", i), len, 16 + tv[i].data.len());
      check($sformatf("vec%0d_bits", i), got, ev);
    end
    trace0(8'h55, 1'b0, -1, o, b, u);
    ev = s2v("01111110 10101010", 1);
    check("underrun_out", o, ev[39:0]);
    check("underrun_busy", b, 40'hFFFFFF);
    check("underrun_pulse", u, 40'h8000);
    trace0(8'hAA, 1'b1, 10, o, b, u);
    ev = s2v("01111110 010", 1);
    check("abort_out", o, ev[39:0]);
    check("abort_busy", b, 40'h7FFFF);
    check("abort_underrun", u, 40'h0);
    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, 4);
      by = '0;
      for (int j = 0; j < n; j++) by[8*j +: 8] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      model(by, n, elen, ev);
      run0(by, n, len, got);
      check("rnd_len", len, elen);
      check("rnd_bits", got, ev);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
